// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bundles the memory fetch port, the redirect request and the
//               decoder valid/ready handshake of the instruction fetch stage.
//               master : the fetch stage (drives fetchAddress and the instr*
//                        outputs).
//               slave  : the environment (memory, controller, decoder).
//               fetchCount is present only when IFETCH_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
    logic [15:0] fetchAddress;
    logic [31:0] fetchOutput;
    logic        redirectValid;
    logic [15:0] redirectTarget;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [15:0] instrPc;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetchCount;
`endif

    modport master (
        output fetchAddress,
        input  fetchOutput,
        input  redirectValid,
        input  redirectTarget,
        output instrValid,
        input  instrReady,
        output instr,
`ifdef IFETCH_PERF_EN
        output instrPc,
        output fetchCount
`else
        output instrPc
`endif
    );

    modport slave (
        input  fetchAddress,
        output fetchOutput,
        output redirectValid,
        output redirectTarget,
        input  instrValid,
        output instrReady,
        input  instr,
`ifdef IFETCH_PERF_EN
        input  instrPc,
        input  fetchCount
`else
        input  instrPc
`endif
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction fetch stage. Owns the program counter, issues one
//               word address per cycle to a synchronous-read fetch port, and
//               buffers returned words in a 2-entry FIFO that is presented to
//               the decoder with a valid/ready handshake. A redirect flushes
//               buffered and in-flight words and restarts at the target.
// Ports       : clk, rst_n (async, active-low)
//               bus (instruction_fetch_if.master):
//                 fetchAddress/fetchOutput     - memory fetch port
//                 redirectValid/redirectTarget - restart request
//                 instrValid/instrReady        - decoder handshake
//                 instr/instrPc                - head-of-buffer word and pc
//                 fetchCount                   - delivered count (IFETCH_PERF_EN)
// Options     : IFETCH_PERF_EN - adds the saturating fetchCount counter.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire                   clk,
    input  wire                   rst_n,
    instruction_fetch_if.master   bus
);

    logic [15:0] pc_q,        pc_d;
    logic        pending_q,   pending_d;
    logic [15:0] pend_pc_q,   pend_pc_d;
    logic [1:0]  count_q,     count_d;
    logic [31:0] head_word_q, head_word_d;
    logic [15:0] head_pc_q,   head_pc_d;
    logic [31:0] tail_word_q, tail_word_d;
    logic [15:0] tail_pc_q,   tail_pc_d;

    logic [15:0] w_fetch_address;
    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occupancy;
    logic        w_issue;
    logic [1:0]  w_after_pop;

    assign w_fetch_address = bus.redirectValid ? bus.redirectTarget : pc_q;
    assign w_valid         = (count_q != 2'd0);
    assign w_pop           = w_valid & bus.instrReady & ~bus.redirectValid;
    assign w_push          = pending_q & ~bus.redirectValid;
    // Slots committed after this edge: buffered + arriving - leaving.
    // A new issue is allowed only while that leaves room for its word.
    assign w_occupancy     = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, w_pop};
    assign w_issue         = bus.redirectValid | (w_occupancy < 3'd2);
    assign w_after_pop     = count_q - {1'b0, w_pop};

    always_comb begin
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        count_d     = count_q;
        head_word_d = head_word_q;
        head_pc_d   = head_pc_q;
        tail_word_d = tail_word_q;
        tail_pc_d   = tail_pc_q;
        pending_d   = w_issue;

        if (w_issue) begin
            pend_pc_d = w_fetch_address;
            pc_d      = w_fetch_address + 16'd1;
        end

        if (bus.redirectValid) begin
            // Buffer contents and the arriving word are stale; only the
            // count is cleared since entries are masked when count is 0.
            count_d = 2'd0;
        end else begin
            if (w_pop) begin
                head_word_d = tail_word_q;
                head_pc_d   = tail_pc_q;
            end
            if (w_push) begin
                // Written after the shift so a simultaneous push into an
                // emptied head overrides the shifted-in (stale) tail.
                if (w_after_pop == 2'd0) begin
                    head_word_d = bus.fetchOutput;
                    head_pc_d   = pend_pc_q;
                end else begin
                    tail_word_d = bus.fetchOutput;
                    tail_pc_d   = pend_pc_q;
                end
            end
            count_d = w_after_pop + {1'b0, w_push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pending_q   <= 1'b0;
            pend_pc_q   <= 16'h0000;
            count_q     <= 2'd0;
            head_word_q <= 32'h0;
            head_pc_q   <= 16'h0000;
            tail_word_q <= 32'h0;
            tail_pc_q   <= 16'h0000;
        end else begin
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            pend_pc_q   <= pend_pc_d;
            count_q     <= count_d;
            head_word_q <= head_word_d;
            head_pc_q   <= head_pc_d;
            tail_word_q <= tail_word_d;
            tail_pc_q   <= tail_pc_d;
        end
    end

    assign bus.fetchAddress = w_fetch_address;
    assign bus.instrValid   = w_valid;
    assign bus.instr        = w_valid ? head_word_q : 32'h0;
    assign bus.instrPc      = w_valid ? head_pc_q   : 16'h0000;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (w_pop && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.fetchCount = fetch_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A cycle table gives
//               per-cycle inputs and expected fetchAddress/instrValid/instrPc;
//               a scoreboard queue holds the expected delivery order, loaded
//               whenever a reset release or redirect is driven, and is popped
//               on every accepted instruction. The memory model returns
//               32'hA000_0000 + address one cycle after sampling it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk;
    logic rst_n;
    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read fetch port model
    always @(posedge clk) bus.fetchOutput <= 32'hA000_0000 + {16'h0, bus.fetchAddress};

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [15:0] tgt;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] efa;
    } vec_t;

    vec_t        tbl [28];
    logic [15:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;
`ifdef IFETCH_PERF_EN
    logic [31:0] exp_cnt = 32'h0;
`endif

    function automatic vec_t mk(logic rdy, logic redir, logic [15:0] tgt,
                                logic ev, logic [15:0] epc, logic [15:0] efa);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.efa = efa;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reload(input logic [15:0] start);
        sb_q.delete();
        for (int i = 0; i < 16; i++) sb_q.push_back(start + 16'(i));
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [15:0] tgt,
                        input logic ev, input logic [15:0] epc, input logic [15:0] efa);
        logic [15:0] sb_pc;
        @(negedge clk);
        bus.instrReady     = rdy;
        bus.redirectValid  = redir;
        bus.redirectTarget = tgt;
        #1;
        check("fetchAddress", {16'h0, bus.fetchAddress}, {16'h0, efa});
        check("instrValid",   {31'h0, bus.instrValid},   {31'h0, ev});
        check("instrPc",      {16'h0, bus.instrPc},      ev ? {16'h0, epc} : 32'h0);
        check("instr",        bus.instr,                 ev ? 32'hA000_0000 + {16'h0, epc} : 32'h0);
`ifdef IFETCH_PERF_EN
        check("fetchCount",   bus.fetchCount,            exp_cnt);
        if (ev && rdy && !redir) exp_cnt++;
`endif
        if (bus.instrValid && rdy && !redir) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: got delivery pc %h expected none at %0t", bus.instrPc, $time);
            end else begin
                sb_pc = sb_q.pop_front();
                check("sb_pc",   {16'h0, bus.instrPc}, {16'h0, sb_pc});
                check("sb_word", bus.instr,            32'hA000_0000 + {16'h0, sb_pc});
            end
        end
        if (redir) reload(tgt);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rdy redir tgt       ev epc       fetchAddress
        tbl[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0001);
        tbl[2]  = mk(1, 0, 16'h0000, 1, 16'h0000, 16'h0002);
        tbl[3]  = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        tbl[5]  = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        tbl[6]  = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        tbl[7]  = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        tbl[8]  = mk(1, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        tbl[9]  = mk(1, 0, 16'h0000, 1, 16'h0002, 16'h0004);
        tbl[10] = mk(1, 0, 16'h0000, 1, 16'h0003, 16'h0005);
        tbl[11] = mk(0, 0, 16'h0000, 1, 16'h0004, 16'h0006);
        tbl[12] = mk(0, 0, 16'h0000, 1, 16'h0004, 16'h0006);
        tbl[13] = mk(1, 1, 16'h0040, 1, 16'h0004, 16'h0040);  // redirect with full buffer
        tbl[14] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0041);
        tbl[15] = mk(1, 0, 16'h0000, 1, 16'h0040, 16'h0042);
        tbl[16] = mk(1, 0, 16'h0000, 1, 16'h0041, 16'h0043);
        tbl[17] = mk(1, 0, 16'h0000, 1, 16'h0042, 16'h0044);
        tbl[18] = mk(1, 1, 16'hFFFF, 1, 16'h0043, 16'hFFFF);  // redirect over a ready head, pending word
        tbl[19] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[20] = mk(1, 0, 16'h0000, 1, 16'hFFFF, 16'h0001);
        tbl[21] = mk(1, 0, 16'h0000, 1, 16'h0000, 16'h0002);
        tbl[22] = mk(1, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        tbl[23] = mk(1, 1, 16'h0100, 1, 16'h0002, 16'h0100);  // back-to-back redirects
        tbl[24] = mk(1, 1, 16'h0200, 0, 16'h0000, 16'h0200);
        tbl[25] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0201);
        tbl[26] = mk(1, 0, 16'h0000, 1, 16'h0200, 16'h0202);
        tbl[27] = mk(1, 0, 16'h0000, 1, 16'h0201, 16'h0203);

        rst_n              = 1'b0;
        bus.instrReady     = 1'b1;
        bus.redirectValid  = 1'b0;
        bus.redirectTarget = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_instrValid",   {31'h0, bus.instrValid},   32'h0);
        check("rst_instr",        bus.instr,                 32'h0);
        check("rst_instrPc",      {16'h0, bus.instrPc},      32'h0);
        check("rst_fetchAddress", {16'h0, bus.fetchAddress}, {16'h0, RESET_PC});
`ifdef IFETCH_PERF_EN
        check("rst_fetchCount",   bus.fetchCount,            32'h0);
`endif

        // Release mid-cycle so the following rising edge is edge 0
        @(posedge clk);
        #2 rst_n = 1'b1;
        reload(RESET_PC);

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].rdy, tbl[i].redir, tbl[i].tgt, tbl[i].ev, tbl[i].epc, tbl[i].efa);
        end

        // Partial-cycle reset pulse mid-stream
        #2 rst_n = 1'b0;
        #1;
        check("pulse_instrValid",   {31'h0, bus.instrValid},   32'h0);
        check("pulse_instr",        bus.instr,                 32'h0);
        check("pulse_fetchAddress", {16'h0, bus.fetchAddress}, {16'h0, RESET_PC});
`ifdef IFETCH_PERF_EN
        check("pulse_fetchCount",   bus.fetchCount,            32'h0);
        exp_cnt = 32'h0;
`endif
        #1 rst_n = 1'b1;
        reload(RESET_PC);

        step(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        step(1, 0, 16'h0000, 0, 16'h0000, 16'h0001);
        step(1, 0, 16'h0000, 1, 16'h0000, 16'h0002);
        step(1, 0, 16'h0000, 1, 16'h0001, 16'h0003);
        step(1, 0, 16'h0000, 1, 16'h0002, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
